// File: rtl/regfile_write_arbiter.sv
// Arbitrates the regfile write port between processor writeback and three
// hardware event slots (button, collision, frame tick); output is registered.
module regfile_write_arbiter #(
   parameter int unsigned BTN_REG  = 2,
   parameter int unsigned COL_REG  = 3,
   parameter int unsigned TICK_REG = 4,
   parameter int unsigned TICK_DIV = 833334
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        proc_we,
   input  logic [4:0]  proc_reg,
   input  logic [31:0] proc_data,
   input  logic        btn_in,
   input  logic        col_in,
   output logic        out_we,
   output logic [4:0]  out_reg,
   output logic [31:0] out_data,
   output logic [2:0]  pend,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [4:0] BTN_IDX  = 5'(BTN_REG);
   localparam logic [4:0] COL_IDX  = 5'(COL_REG);
   localparam logic [4:0] TICK_IDX = 5'(TICK_REG);

   typedef enum logic [1:0] {RR_BTN, RR_COL, RR_TICK} rr_e;

   rr_e              ptr_q, ptr_d;
   logic [2:0]       pend_q, pend_d;
   logic [31:0]      tick_data_q, tick_data_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [31:0]      frame_q, frame_d;
   logic             btn_hist_q, col_hist_q;
   logic [7:0]       drop_q, drop_d;
   logic             we_q, we_d;
   logic [4:0]       reg_q, reg_d;
   logic [31:0]      data_q, data_d;

   logic [2:0]       ev, grant, cancel, coalesce;
   logic [8:0]       drop_sum;

   always_comb begin
      ev[0] = btn_in & ~btn_hist_q;
      ev[1] = col_in & ~col_hist_q;
      ev[2] = (div_q == DIV_LAST);

      grant = '0;
      if (!proc_we) begin
         unique case (ptr_q)
            RR_BTN:  grant = pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : 3'b000;
            RR_COL:  grant = pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : pend_q[0] ? 3'b001 : 3'b000;
            RR_TICK: grant = pend_q[2] ? 3'b100 : pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : 3'b000;
            default: grant = '0;
         endcase
      end

      ptr_d = ptr_q;
      if (grant[0]) ptr_d = RR_COL;
      if (grant[1]) ptr_d = RR_TICK;
      if (grant[2]) ptr_d = RR_BTN;

      // Only a slot that was already pending can be cancelled by a processor write.
      cancel[0] = proc_we & (proc_reg == BTN_IDX)  & pend_q[0];
      cancel[1] = proc_we & (proc_reg == COL_IDX)  & pend_q[1];
      cancel[2] = proc_we & (proc_reg == TICK_IDX) & pend_q[2];

      coalesce = ev & pend_q & ~grant & ~cancel;
      pend_d   = ev | (pend_q & ~grant & ~cancel);
      drop_sum = 9'(drop_q) + 9'(coalesce[0]) + 9'(coalesce[1]) + 9'(coalesce[2]);
      drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

      div_d       = ev[2] ? '0 : div_q + DIV_W'(1);
      frame_d     = ev[2] ? frame_q + 32'd1 : frame_q;
      tick_data_d = ev[2] ? frame_q + 32'd1 : tick_data_q;

      we_d   = proc_we | (|grant);
      reg_d  = reg_q;
      data_d = data_q;
      if (proc_we) begin
         reg_d  = proc_reg;
         data_d = proc_data;
      end else if (grant[0]) begin
         reg_d  = BTN_IDX;
         data_d = 32'd1;
      end else if (grant[1]) begin
         reg_d  = COL_IDX;
         data_d = 32'd1;
      end else if (grant[2]) begin
         reg_d  = TICK_IDX;
         data_d = tick_data_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q       <= RR_BTN;
         pend_q      <= '0;
         tick_data_q <= '0;
         div_q       <= '0;
         frame_q     <= '0;
         btn_hist_q  <= 1'b0;
         col_hist_q  <= 1'b0;
         drop_q      <= '0;
         we_q        <= 1'b0;
         reg_q       <= '0;
         data_q      <= '0;
      end else begin
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         tick_data_q <= tick_data_d;
         div_q       <= div_d;
         frame_q     <= frame_d;
         btn_hist_q  <= btn_in;
         col_hist_q  <= col_in;
         drop_q      <= drop_d;
         we_q        <= we_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
      end
   end

   assign out_we   = we_q;
   assign out_reg  = reg_q;
   assign out_data = data_q;
   assign pend     = pend_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// slot/queue-style reference model evaluated once per rising edge.
module tb_regfile_write_arbiter;

   localparam int unsigned TDIV = 4;

   logic        clock = 1'b0;
   logic        reset, proc_we, btn_in, col_in;
   logic [4:0]  proc_reg;
   logic [31:0] proc_data;
   logic        out_we;
   logic [4:0]  out_reg;
   logic [31:0] out_data;
   logic [2:0]  pend;
   logic [7:0]  drop_cnt;

   int n_pass = 0;
   int n_total = 0;

   regfile_write_arbiter #(.BTN_REG(2), .COL_REG(3), .TICK_REG(4), .TICK_DIV(TDIV)) dut (
      .clock(clock), .reset(reset), .proc_we(proc_we), .proc_reg(proc_reg),
      .proc_data(proc_data), .btn_in(btn_in), .col_in(col_in), .out_we(out_we),
      .out_reg(out_reg), .out_data(out_data), .pend(pend), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   // Reference model: slot 0 = button, 1 = collision, 2 = tick.
   int unsigned slot_reg [3] = '{2, 3, 4};
   bit          mp [3];
   logic [31:0] md [3];
   int          mptr, mdiv, mdrop;
   logic [31:0] mframe;
   bit          mhb, mhc, mwe;
   logic [4:0]  mreg;
   logic [31:0] mdat;

   function automatic void model_step();
      bit ev [3];
      int g;
      bit canc;
      if (reset) begin
         for (int s = 0; s < 3; s++) begin mp[s] = 0; md[s] = '0; end
         mptr = 0; mdiv = 0; mdrop = 0; mframe = '0;
         mhb = 0; mhc = 0; mwe = 0; mreg = '0; mdat = '0;
         return;
      end
      ev[0] = btn_in && !mhb;
      ev[1] = col_in && !mhc;
      ev[2] = (mdiv == TDIV - 1);
      g = -1;
      if (proc_we) begin
         mwe = 1; mreg = proc_reg; mdat = proc_data;
      end else begin
         for (int k = 0; k < 3; k++)
            if (g < 0 && mp[(mptr + k) % 3]) g = (mptr + k) % 3;
         mwe = (g >= 0);
         if (g >= 0) begin
            mreg = 5'(slot_reg[g]); mdat = md[g]; mptr = (g + 1) % 3;
         end
      end
      for (int s = 0; s < 3; s++) begin
         canc = proc_we && (int'(proc_reg) == int'(slot_reg[s])) && mp[s];
         if (ev[s]) begin
            if (mp[s] && g != s && !canc && mdrop < 255) mdrop++;
            mp[s] = 1;
            md[s] = (s == 2) ? mframe + 32'd1 : 32'd1;
         end else if (g == s || canc) begin
            mp[s] = 0;
         end
      end
      if (ev[2]) begin mframe = mframe + 32'd1; mdiv = 0; end
      else mdiv++;
      mhb = btn_in; mhc = col_in;
   endfunction

   task automatic clk();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      proc_we = 0; proc_reg = '0; proc_data = '0; btn_in = 0; col_in = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      repeat (10) clk();
      n_total++;
      if ({out_we, out_reg, out_data, pend, drop_cnt} !== 49'd0)
         $display("FAIL reset: got we=%0b reg=%0d data=%h pend=%b drop=%0d, want all 0",
                  out_we, out_reg, out_data, pend, drop_cnt);
      else n_pass++;
   endtask

   task automatic test_proc_hold();
      reset = 1; clk(); reset = 0;
      proc_we = 1; proc_reg = 5'd9;
      for (int i = 0; i < 10; i++) begin
         proc_data = $urandom;
         clk();
         n_total++;
         if ({out_we, out_reg, out_data} !== {1'b1, 5'd9, proc_data})
            $display("FAIL hold_wr: got we=%0b reg=%0d data=%h, want 1/9/%h", out_we, out_reg, out_data, proc_data);
         else n_pass++;
      end
      n_total++;
      if ({pend, drop_cnt} !== {3'b100, 8'd1} || {pend, drop_cnt} !== {mp[2], mp[1], mp[0], 8'(mdrop)})
         $display("FAIL hold_status: got pend=%b drop=%0d, want pend=100 drop=1", pend, drop_cnt);
      else n_pass++;
      proc_we = 0;
      clk();
      n_total++;
      if ({out_we, out_reg, out_data} !== {1'b1, 5'd4, 32'd2})
         $display("FAIL hold_release: got we=%0b reg=%0d data=%0d, want 1/4/2", out_we, out_reg, out_data);
      else n_pass++;
   endtask

   task automatic test_rr();
      bit          xwe  [6] = '{0, 1, 1, 0, 1, 1};
      logic [4:0]  xreg [6] = '{0, 2, 3, 0, 4, 3};
      bit          colv [6] = '{1, 0, 0, 1, 1, 1};
      reset = 1; clk(); reset = 0;
      idle_inputs();
      btn_in = 1;
      for (int i = 0; i < 6; i++) begin
         col_in = colv[i];
         clk();
         n_total++;
         if (out_we !== xwe[i] || (xwe[i] && (out_reg !== xreg[i] || out_data !== 32'd1)))
            $display("FAIL rr_order[%0d]: got we=%0b reg=%0d data=%0d, want we=%0b reg=%0d data=1",
                     i, out_we, out_reg, out_data, xwe[i], xreg[i]);
         else n_pass++;
         n_total++;
         if ({pend, drop_cnt} !== {mp[2], mp[1], mp[0], 8'(mdrop)})
            $display("FAIL rr_status[%0d]: got pend=%b drop=%0d, want pend=%b drop=%0d",
                     i, pend, drop_cnt, {mp[2], mp[1], mp[0]}, mdrop);
         else n_pass++;
      end
   endtask

   task automatic test_cancel();
      int hw_col_writes = 0;
      reset = 1; clk(); reset = 0;
      idle_inputs();
      proc_we = 1; proc_reg = 5'd9; proc_data = 32'hAAAA_0000; col_in = 1;
      clk();
      proc_reg = 5'd3; proc_data = 32'd0;
      clk();
      n_total++;
      if (pend[1] !== 1'b0 || drop_cnt !== 8'd0 || out_reg !== 5'd3 || out_data !== 32'd0)
         $display("FAIL cancel: got pend=%b drop=%0d reg=%0d data=%0d, want pend[1]=0 drop=0 reg=3 data=0",
                  pend, drop_cnt, out_reg, out_data);
      else n_pass++;
      proc_we = 0;
      for (int i = 0; i < 6; i++) begin
         clk();
         if (out_we && out_reg == 5'd3) hw_col_writes++;
         n_total++;
         if ({out_we, out_reg, out_data, pend, drop_cnt} !== {mwe, mreg, mdat, mp[2], mp[1], mp[0], 8'(mdrop)})
            $display("FAIL cancel_model[%0d]: got we=%0b reg=%0d data=%h pend=%b drop=%0d, want we=%0b reg=%0d data=%h",
                     i, out_we, out_reg, out_data, pend, drop_cnt, mwe, mreg, mdat);
         else n_pass++;
      end
      n_total++;
      if (hw_col_writes !== 0)
         $display("FAIL cancel_nowrite: got %0d reg3 writes, want 0", hw_col_writes);
      else n_pass++;
   endtask

   task automatic test_saturate();
      int reg2_writes = 0;
      int errs = 0;
      reset = 1; clk(); reset = 0;
      idle_inputs();
      proc_we = 1; proc_reg = 5'd9;
      for (int i = 0; i < 600; i++) begin
         btn_in = (i % 2 == 0);
         proc_data = $urandom;
         clk();
         if ({out_we, out_reg, out_data, pend, drop_cnt} !== {mwe, mreg, mdat, mp[2], mp[1], mp[0], 8'(mdrop)})
            errs++;
      end
      n_total++;
      if (errs !== 0) $display("FAIL sat_model: got %0d cycle disagreements, want 0", errs);
      else n_pass++;
      n_total++;
      if (drop_cnt !== 8'd255) $display("FAIL sat_drop: got %0d, want 255", drop_cnt);
      else n_pass++;
      proc_we = 0; btn_in = 0;
      for (int i = 0; i < 10; i++) begin
         clk();
         if (out_we && out_reg == 5'd2) reg2_writes++;
      end
      n_total++;
      if (reg2_writes !== 1) $display("FAIL sat_release: got %0d reg2 writes, want 1", reg2_writes);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      reset = 1; clk(); reset = 0;
      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 299) == 0);
         proc_we   = ($urandom_range(0, 99) < 45);
         proc_reg  = 5'($urandom_range(0, 7));
         proc_data = $urandom;
         if ($urandom_range(0, 2) == 0) btn_in = ~btn_in;
         if ($urandom_range(0, 3) == 0) col_in = ~col_in;
         clk();
         if ({out_we, out_reg, out_data, pend, drop_cnt} !== {mwe, mreg, mdat, mp[2], mp[1], mp[0], 8'(mdrop)}) begin
            errs++;
            if (errs <= 5)
               $display("FAIL rand[%0d]: got we=%0b reg=%0d data=%h pend=%b drop=%0d, want we=%0b reg=%0d data=%h pend=%b drop=%0d",
                        i, out_we, out_reg, out_data, pend, drop_cnt, mwe, mreg, mdat, {mp[2], mp[1], mp[0]}, mdrop);
         end
      end
      n_total++;
      if (errs !== 0) $display("FAIL rand_total: got %0d disagreements, want 0", errs);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_proc_hold();
      test_rr();
      test_cancel();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
